// File: rtl/config_stream_loader.sv
// config_stream_loader: frames a header/count/record/checksum byte stream into 32-bit config writes
module config_stream_loader #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_write,
  output logic [15:0] records_written,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, REC, WRITE, CHK, DONE, ERROR} state_t;
  state_t      state;
  logic [15:0] count;
  logic [63:0] rec;
  logic [2:0]  idx;
  logic [7:0]  csum;
  logic        take;
  logic [63:0] rec_next;
  assign take = in_valid && in_ready;
  assign rec_next = {rec[55:0], in_data};
  // The strobe, bus and write count are registered on the edge that takes byte 7,
  // so they are all valid together during the single WRITE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      rec <= '0;
      idx <= '0;
      csum <= '0;
      in_ready <= 1'b0;
      config_addr <= '0;
      config_data <= '0;
      config_write <= 1'b0;
      records_written <= '0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      config_write <= 1'b0;
      in_ready <= 1'b1;
      case (state)
        IDLE, DONE, ERROR:
          if (take && in_data == HEADER) begin
            state <= CNT_HI;
            csum <= '0;
            records_written <= '0;
            done <= 1'b0;
            error <= 1'b0;
          end
        CNT_HI:
          if (take) begin
            count[15:8] <= in_data;
            state <= CNT_LO;
          end
        CNT_LO:
          if (take) begin
            count[7:0] <= in_data;
            idx <= '0;
            state <= ({count[15:8], in_data} != 16'd0) ? REC : CHK;
          end
        REC:
          if (take) begin
            rec <= rec_next;
            csum <= csum ^ in_data;
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= WRITE;
              in_ready <= 1'b0;
              config_addr <= rec_next[63:32];
              config_data <= rec_next[31:0];
              config_write <= 1'b1;
              records_written <= records_written + 16'd1;
            end
          end
        WRITE: begin
          idx <= '0;
          state <= (records_written == count) ? CHK : REC;
        end
        CHK:
          if (take) begin
            state <= (in_data == csum) ? DONE : ERROR;
            done <= in_data == csum;
            error <= in_data != csum;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_config_stream_loader.sv
// tb_config_stream_loader: directed checks of framing, checksum, back-pressure and reset behaviour
module tb_config_stream_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_write;
  logic [15:0] records_written;
  logic        done;
  logic        error;
  int          checks = 0;
  int          errors = 0;
  int          rdy_low = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  always #5 clk = ~clk;

  config_stream_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .config_addr(config_addr), .config_data(config_data), .config_write(config_write),
    .records_written(records_written), .done(done), .error(error)
  );

  always @(posedge clk) begin
    #1;
    if (config_write) begin
      wa.push_back(config_addr);
      wd.push_back(config_data);
    end
  end

  always @(negedge clk) if (reset && !in_ready) rdy_low++;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Called at a negedge; returns at the negedge after the byte has transferred.
  task automatic send(input logic [7:0] b);
    in_data = b;
    in_valid = 1'b1;
    for (int i = 0; i < 4 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_basic(input logic [7:0] chk);
    logic [7:0] v[12];
    v = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00};
    v[11] = chk;
    for (int i = 0; i < 12; i++) send(v[i]);
  endtask

  task automatic test_reset;
    #12;
    checks++; if ({in_ready, config_write, done, error} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b required 0000", {in_ready, config_write, done, error}); end
    checks++; if ({config_addr, config_data, records_written} !== 80'd0) begin errors++; $display("FAIL reset_bus got %h required 0", {config_addr, config_data, records_written}); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", in_ready); end
  endtask

  task automatic test_basic;
    logic [7:0] v[11];
    v = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0F};
    wa.delete();
    wd.delete();
    for (int i = 0; i < 11; i++) send(v[i]);
    checks++; if (config_write !== 1'b1) begin errors++; $display("FAIL basic_strobe got %b required 1", config_write); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_write_ready got %b required 0", in_ready); end
    checks++; if (config_addr !== 32'h1 || config_data !== 32'hF) begin errors++; $display("FAIL basic_bus got %h/%h required 00000001/0000000f", config_addr, config_data); end
    send(8'h0E);
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL basic_result done=%b error=%b required 1 0", done, error); end
    checks++; if (records_written !== 16'd1) begin errors++; $display("FAIL basic_count got %0d required 1", records_written); end
    checks++; if (wa.size() != 1) begin errors++; $display("FAIL basic_writes got %0d required 1", wa.size()); end
  endtask

  task automatic test_empty;
    wa.delete();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL empty_result done=%b error=%b required 1 0", done, error); end
    checks++; if (records_written !== 16'd0) begin errors++; $display("FAIL empty_count got %0d required 0", records_written); end
    checks++; if (wa.size() != 0) begin errors++; $display("FAIL empty_writes got %0d required 0", wa.size()); end
    checks++; if (config_addr !== 32'h1 || config_data !== 32'hF) begin errors++; $display("FAIL empty_hold got %h/%h required 00000001/0000000f", config_addr, config_data); end
  endtask

  task automatic test_bad_checksum;
    wa.delete();
    send_basic(8'h0F);
    checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL bad_result done=%b error=%b required 0 1", done, error); end
    checks++; if (wa.size() != 1 || records_written !== 16'd1) begin errors++; $display("FAIL bad_writes got %0d/%0d required 1/1", wa.size(), records_written); end
  endtask

  task automatic test_garbage;
    wa.delete();
    wd.delete();
    send(8'h00); send(8'hFF); send(8'h3C);
    send_basic(8'h0E);
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL garbage_result done=%b error=%b required 1 0", done, error); end
    checks++; if (wa.size() != 1) begin errors++; $display("FAIL garbage_writes got %0d required 1", wa.size()); end
    else begin
      checks++; if (wa[0] !== 32'h1 || wd[0] !== 32'hF) begin errors++; $display("FAIL garbage_bus got %h/%h required 00000001/0000000f", wa[0], wd[0]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] v[20];
    v = '{8'hA5, 8'h00, 8'h02,
          8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
          8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h55, 8'hB6};
    wa.delete();
    wd.delete();
    rdy_low = 0;
    for (int i = 0; i < 20; i++) begin
      send(v[i]);
      @(negedge clk);
    end
    checks++; if (rdy_low != 2) begin errors++; $display("FAIL bp_ready_low got %0d required 2", rdy_low); end
    checks++; if (done !== 1'b1 || records_written !== 16'd2) begin errors++; $display("FAIL bp_result done=%b count=%0d required 1 2", done, records_written); end
    checks++; if (wa.size() != 2) begin errors++; $display("FAIL bp_writes got %0d required 2", wa.size()); end
    else begin
      checks++; if (wa[0] !== 32'h12345678 || wd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_rec0 got %h/%h required 12345678/deadbeef", wa[0], wd[0]); end
      checks++; if (wa[1] !== 32'hCAFEF00D || wd[1] !== 32'h00000055) begin errors++; $display("FAIL bp_rec1 got %h/%h required cafef00d/00000055", wa[1], wd[1]); end
    end
  endtask

  task automatic test_reset_mid_record;
    logic [7:0] v[8];
    v = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 8; i++) send(v[i]);
    #2 reset = 1'b0;
    #1;
    checks++; if ({in_ready, config_write, done, error} !== 4'b0) begin errors++; $display("FAIL mid_reset_flags got %b required 0000", {in_ready, config_write, done, error}); end
    checks++; if ({config_addr, config_data, records_written} !== 80'd0) begin errors++; $display("FAIL mid_reset_bus got %h required 0", {config_addr, config_data, records_written}); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b required 1", in_ready); end
    wa.delete();
    send_basic(8'h0E);
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL mid_reload_result done=%b error=%b required 1 0", done, error); end
    checks++; if (wa.size() != 1 || records_written !== 16'd1) begin errors++; $display("FAIL mid_reload_writes got %0d/%0d required 1/1", wa.size(), records_written); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_empty;
    test_bad_checksum;
    test_garbage;
    test_back_to_back;
    test_reset_mid_record;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
